// File: rtl/snn_pkg.sv
// Shared SNN constants and the serialized spike event record.
package snn_pkg;

    localparam int N_INPUT  = 8;
    localparam int N_HIDDEN = 30;
    localparam int IDX_W    = 5;
    localparam int TS_W     = 16;

    localparam logic LAYER_INPUT  = 1'b0;
    localparam logic LAYER_HIDDEN = 1'b1;

    typedef struct packed {
        logic             layer;
        logic [IDX_W-1:0] index;
        logic [TS_W-1:0]  timestamp;
    } evt_t;

endpackage

// File: rtl/lowest_set_encoder.sv
// Combinational priority encoder: reports the lowest set bit of a vector.
module lowest_set_encoder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 5
) (
    input  logic [WIDTH-1:0] bits,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    always_comb begin
        found = 1'b0;
        index = '0;
        // Scanning downward lets the lowest set bit overwrite the result last.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (bits[i]) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/spike_event_serializer.sv
// Collects per-cycle edge pulses from two layers into pending masks and
// streams them out as single-neuron events over a valid/ready handshake.
module spike_event_serializer
    import snn_pkg::*;
#(
    parameter int N_INPUT  = snn_pkg::N_INPUT,
    parameter int N_HIDDEN = snn_pkg::N_HIDDEN,
    parameter int IDX_W    = snn_pkg::IDX_W,
    parameter int TS_W     = snn_pkg::TS_W,
    parameter int DROP_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                boot_mode,
    input  logic [N_INPUT-1:0]  input_layer_edge,
    input  logic [N_HIDDEN-1:0] hidden_layer_edge,
    input  logic                ts_tick,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic                evt_layer,
    output logic [IDX_W-1:0]    evt_index,
    output logic [TS_W-1:0]     evt_timestamp,
    output logic                overrun,
    output logic [DROP_W-1:0]   drop_count,
    output logic                idle
);

    logic [N_INPUT-1:0]  p_in;
    logic [N_HIDDEN-1:0] p_hid;
    logic [N_INPUT-1:0]  edge_in;
    logic [N_HIDDEN-1:0] edge_hid;
    logic [N_INPUT-1:0]  grant_in;
    logic [N_HIDDEN-1:0] grant_hid;
    logic [TS_W-1:0]     ts;
    logic                in_found;
    logic                hid_found;
    logic [IDX_W-1:0]    in_idx;
    logic [IDX_W-1:0]    hid_idx;
    logic                free;
    logic                collide;

    lowest_set_encoder #(.WIDTH(N_INPUT), .IDX_W(IDX_W)) enc_in (
        .bits  (p_in),
        .found (in_found),
        .index (in_idx)
    );

    lowest_set_encoder #(.WIDTH(N_HIDDEN), .IDX_W(IDX_W)) enc_hid (
        .bits  (p_hid),
        .found (hid_found),
        .index (hid_idx)
    );

    assign edge_in  = input_layer_edge & {N_INPUT{!boot_mode}};
    assign edge_hid = hidden_layer_edge & {N_HIDDEN{!boot_mode}};
    assign free     = !evt_valid || evt_ready;

    always_comb begin
        grant_in  = '0;
        grant_hid = '0;
        if (free) begin
            if (in_found) begin
                grant_in = N_INPUT'(1) << in_idx;
            end else if (hid_found) begin
                grant_hid = N_HIDDEN'(1) << hid_idx;
            end
        end
    end

    // A re-fire onto the bit being granted this cycle is a fresh event, not a loss.
    assign collide = (|(p_in & ~grant_in & edge_in))
                   | (|(p_hid & ~grant_hid & edge_hid));

    assign idle = (p_in == '0) && (p_hid == '0) && !evt_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_in          <= '0;
            p_hid         <= '0;
            evt_valid     <= 1'b0;
            evt_layer     <= 1'b0;
            evt_index     <= '0;
            evt_timestamp <= '0;
            ts            <= '0;
            overrun       <= 1'b0;
            drop_count    <= '0;
        end else begin
            p_in  <= (p_in & ~grant_in) | edge_in;
            p_hid <= (p_hid & ~grant_hid) | edge_hid;

            if (free) begin
                if (in_found) begin
                    evt_valid     <= 1'b1;
                    evt_layer     <= LAYER_INPUT;
                    evt_index     <= in_idx;
                    evt_timestamp <= ts;
                end else if (hid_found) begin
                    evt_valid     <= 1'b1;
                    evt_layer     <= LAYER_HIDDEN;
                    evt_index     <= hid_idx;
                    evt_timestamp <= ts;
                end else begin
                    evt_valid <= 1'b0;
                end
            end

            if (boot_mode) begin
                ts <= '0;
            end else if (ts_tick) begin
                ts <= ts + 1'b1;
            end

            if (collide) begin
                overrun <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + 1'b1;
                end
            end
        end
    end

endmodule
